alu_rr_scheduler: RTL
=====================

// Module: alu_rr_scheduler
// PURPOSE
//  Round-robin scheduler sharing one 16-bit ALU (1-cycle registered, en-gated) among NUM_REQ requesters.
//  Accepts one op per cycle, drives the ALU operand/opcode/en ports and returns each result tagged with the requester id.
//  Sits between the issue-side requesters and the ALU instance; one op in flight, one result slot.
// PARAMETERS
//  NUM_REQ  4   number of requesters (2..2**ID_W)
//  ID_W     2   width of resp_id
//  DATA_W   16  operand/result width; fixed at 16 to match the ALU
// PORTS
//  clk         in   1              clock, rising edge
//  rst         in   1              asynchronous, active-low reset (rst=0 resets)
//  req_valid   in   NUM_REQ        requester i has an op pending
//  req_ready   out  NUM_REQ        one-hot grant; op of requester i accepted this cycle
//  req_op1     in   NUM_REQ*16     requester i operand 1 at [16*i +: 16]
//  req_op2     in   NUM_REQ*16     requester i operand 2 at [16*i +: 16]
//  req_opcode  in   NUM_REQ*4      requester i opcode at [4*i +: 4]
//  req_cin     in   NUM_REQ        requester i carry/borrow in
//  alu_op1     out  16             to ALU op1
//  alu_op2     out  16             to ALU op2
//  alu_opcode  out  4              to ALU opcode
//  alu_cin     out  1              to ALU cin
//  alu_en      out  1              to ALU en; high only in an issue cycle
//  alu_out     in   16             from ALU out
//  alu_cb      in   1              from ALU cb
//  resp_valid  out  1              result available
//  resp_ready  in   1              consumer takes result this cycle
//  resp_id     out  ID_W           requester index owning the result
//  resp_out    out  16             result
//  resp_cb     out  1              carry/borrow
//  resp_err    out  1              op used reserved opcode 4'b0111
// BEHAVIOUR
//  Reset (rst=0, async): inflight=0, rr_ptr=0, err_q=0, id_q=0.
//    Outputs while in reset: req_ready=0, alu_en=0, resp_valid=0, resp_id=0, resp_err=0.
//  Reset mid-operation: in-flight op discarded, no response produced, ALU contents ignored.
//    After release, req0 has top priority.
//  Issue condition (cycle C): can_issue = !inflight || resp_ready; also needs any req_valid.
//  Arbitration: search req_valid from rr_ptr upward, modulo NUM_REQ; first hit g wins.
//    In the issue cycle: req_ready[g]=1 and all other req_ready bits 0.
//    At the edge: rr_ptr <= (g+1) mod NUM_REQ.
//    rr_ptr is unchanged in any cycle with no issue.
//  Issue, normal opcode: alu_* = requester g fields, alu_en=1.
//    At the edge: inflight<=1, id_q<=g, err_q<=0.
//  Issue, opcode 4'b0111 (reserved): alu_en=0; alu_* still driven with requester g fields.
//    At the edge: inflight<=1, id_q<=g, err_q<=1.
//  Non-issue cycle: alu_en=0 and alu_op1/op2/opcode/cin driven 0.
//    ALU holds its output, so alu_out stays stable for a stalled response.
//  Response (cycle C+1): resp_valid=inflight, resp_id=id_q, resp_err=err_q.
//    resp_out/resp_cb = err_q ? 0 : alu_out/alu_cb (combinational passthrough).
//    Latency: 1 cycle from acceptance to resp_valid.
//  Response with no new issue: resp_valid && resp_ready and no issue -> inflight<=0.
//  Response with new issue: resp_valid && resp_ready and an issue in the same cycle -> inflight stays 1.
//    Throughput is 1 op/cycle.
//  Stall: resp_valid && !resp_ready -> no issue, req_ready=0.
//    resp_* held stable until accepted.
//  Requester op fields need to be stable only in the cycle req_ready is high.
//  ALU rst input is not driven by this block; the ALU must not be reset while inflight=1.
// TESTING
//  1. Only req0: add op1=0x0005 op2=0x0003 cin=1
//     -> req_ready=0001, alu_en=1 for one cycle
//     -> next cycle resp_valid=1, id=0, out=0x0009, cb=0, err=0.
//  2. All four req_valid held with resp_ready=1, rr_ptr=0
//     -> grants 0,1,2,3,0 on consecutive cycles, back-to-back responses with ids 0,1,2,3,0.
//  3. resp_ready=0 for 3 cycles with req1/req2 pending
//     -> req_ready=0, alu_en=0, resp_* constant.
//     -> resp_ready=1: response consumed and req1 issued in the same cycle.
//  4. req2 opcode=4'b0111 -> alu_en stays 0; next cycle resp_valid=1, id=2, err=1, out=0x0000, cb=0.
//  5. req3 sub op1=0x0000 op2=0x0001 cin=0 -> resp_out=0xFFFF, cb=1, id=3.
//  6. Drive rst=0 while inflight=1 -> resp_valid drops without a clock edge.
//     -> after release, first grant goes to req0 with all four valid.

Source files
------------

// File: rtl/alu_rr_scheduler_if.sv
// rtl/alu_rr_scheduler_if.sv - requester, ALU and response signals of the round-robin ALU scheduler
interface alu_rr_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int DATA_W  = 16
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*DATA_W-1:0] req_op1;
    logic [NUM_REQ*DATA_W-1:0] req_op2;
    logic [NUM_REQ*4-1:0]      req_opcode;
    logic [NUM_REQ-1:0]        req_cin;
    logic [DATA_W-1:0]         alu_op1;
    logic [DATA_W-1:0]         alu_op2;
    logic [3:0]                alu_opcode;
    logic                      alu_cin;
    logic                      alu_en;
    logic [DATA_W-1:0]         alu_out;
    logic                      alu_cb;
    logic                      resp_valid;
    logic                      resp_ready;
    logic [ID_W-1:0]           resp_id;
    logic [DATA_W-1:0]         resp_out;
    logic                      resp_cb;
    logic                      resp_err;

    modport slave (
        input  req_valid, req_op1, req_op2, req_opcode, req_cin,
        input  alu_out, alu_cb, resp_ready,
        output req_ready, alu_op1, alu_op2, alu_opcode, alu_cin, alu_en,
        output resp_valid, resp_id, resp_out, resp_cb, resp_err
    );

    modport master (
        output req_valid, req_op1, req_op2, req_opcode, req_cin,
        output alu_out, alu_cb, resp_ready,
        input  req_ready, alu_op1, alu_op2, alu_opcode, alu_cin, alu_en,
        input  resp_valid, resp_id, resp_out, resp_cb, resp_err
    );
endinterface

// File: rtl/alu_rr_scheduler.sv
// rtl/alu_rr_scheduler.sv - round-robin sharing of one registered 16-bit ALU among NUM_REQ requesters
module alu_rr_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int DATA_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    alu_rr_scheduler_if.slave    bus
);
    localparam logic [3:0] OPC_RSVD = 4'b0111;

    logic            inflight_q, inflight_d;
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0] id_q, id_d;
    logic            err_q, err_d;

    logic              found;
    logic [ID_W-1:0]   grant;
    logic [ID_W-1:0]   idx;
    logic              issue;
    logic [DATA_W-1:0] sel_op1, sel_op2;
    logic [3:0]        sel_opcode;
    logic              sel_cin;
    logic              sel_rsvd;

    // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        found = 1'b0;
        grant = '0;
        idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
            if (!found && bus.req_valid[idx]) begin
                found = 1'b1;
                grant = idx;
            end
        end
    end

    assign sel_op1    = bus.req_op1[int'(grant)*DATA_W +: DATA_W];
    assign sel_op2    = bus.req_op2[int'(grant)*DATA_W +: DATA_W];
    assign sel_opcode = bus.req_opcode[int'(grant)*4 +: 4];
    assign sel_cin    = bus.req_cin[grant];
    assign sel_rsvd   = (sel_opcode == OPC_RSVD);

    // The single result slot frees up in the same cycle it is consumed.
    assign issue = rst && found && (!inflight_q || bus.resp_ready);

    always_comb begin
        bus.req_ready  = '0;
        bus.alu_en     = 1'b0;
        bus.alu_op1    = '0;
        bus.alu_op2    = '0;
        bus.alu_opcode = '0;
        bus.alu_cin    = 1'b0;
        if (issue) begin
            bus.req_ready[grant] = 1'b1;
            bus.alu_en           = !sel_rsvd;
            bus.alu_op1          = sel_op1;
            bus.alu_op2          = sel_op2;
            bus.alu_opcode       = sel_opcode;
            bus.alu_cin          = sel_cin;
        end
    end

    always_comb begin
        inflight_d = inflight_q;
        rr_ptr_d   = rr_ptr_q;
        id_d       = id_q;
        err_d      = err_q;
        if (issue) begin
            inflight_d = 1'b1;
            rr_ptr_d   = ID_W'((int'(grant) + 1) % NUM_REQ);
            id_d       = grant;
            err_d      = sel_rsvd;
        end else if (inflight_q && bus.resp_ready) begin
            inflight_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight_q <= 1'b0;
            rr_ptr_q   <= '0;
            id_q       <= '0;
            err_q      <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
            rr_ptr_q   <= rr_ptr_d;
            id_q       <= id_d;
            err_q      <= err_d;
        end
    end

    // The ALU holds its output while en is low, so a stalled result stays stable.
    assign bus.resp_valid = inflight_q;
    assign bus.resp_id    = id_q;
    assign bus.resp_err   = err_q;
    assign bus.resp_out   = err_q ? '0 : bus.alu_out;
    assign bus.resp_cb    = err_q ? 1'b0 : bus.alu_cb;
endmodule
